// File: rtl/vdma_frame_arbiter.sv
// vdma_frame_arbiter: frame-granular round-robin arbiter merging two VDMA MM2S
// AXI4-Stream sources (tuser=SOF, tlast=EOL) onto one downstream stream.
// A grant is held until the latched number of lines (vdma_row, 0 treated as 1)
// has passed; the granted source is passed through combinationally.
// Optional feature macro: ARB_STATS_EN adds frame_cnt0/frame_cnt1/drop_cnt outputs.
module vdma_frame_arbiter #(
   parameter int unsigned TDATA_WIDTH = 64,
   parameter int unsigned ROW_W       = 32
) (
   input  logic                   s_axis_aclk,
   input  logic                   s_axis_aresetn,
   input  logic [ROW_W-1:0]       vdma_row,
   input  logic [TDATA_WIDTH-1:0] s0_axis_tdata,
   input  logic                   s0_axis_tlast,
   input  logic                   s0_axis_tuser,
   input  logic                   s0_axis_tvalid,
   output logic                   s0_axis_tready,
   input  logic [TDATA_WIDTH-1:0] s1_axis_tdata,
   input  logic                   s1_axis_tlast,
   input  logic                   s1_axis_tuser,
   input  logic                   s1_axis_tvalid,
   output logic                   s1_axis_tready,
   output logic [TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tuser,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
`ifdef ARB_STATS_EN
   output logic [ROW_W-1:0]       frame_cnt0,
   output logic [ROW_W-1:0]       frame_cnt1,
   output logic [ROW_W-1:0]       drop_cnt,
`endif
   output logic [1:0]             grant,
   output logic                   frame_done,
   output logic                   sof_err
);

   typedef enum logic {ST_IDLE, ST_PASS} state_t;

   state_t           r_state,      w_state_nxt;
   logic [1:0]       r_grant,      w_grant_nxt;
   logic             r_rr_last,    w_rr_last_nxt;   // 1: s1 owned the last frame
   logic [ROW_W-1:0] r_line_cnt,   w_line_cnt_nxt;
   logic [ROW_W-1:0] r_rows_lat,   w_rows_lat_nxt;
   logic             r_first,      w_first_nxt;     // next handshake is the frame's first beat
   logic             r_sof_err,    w_sof_err_nxt;
   logic             r_frame_done, w_frame_done_nxt;

   logic             w_req0, w_req1;
   logic             w_flush0, w_flush1;
   logic             w_done;
   logic             w_sel_valid, w_sel_last, w_sel_user, w_hs;

   assign w_req0 = s0_axis_tvalid & s0_axis_tuser;
   assign w_req1 = s1_axis_tvalid & s1_axis_tuser;

   // Next-state, arbitration and stream routing.
   always_comb begin
      w_state_nxt      = r_state;
      w_grant_nxt      = r_grant;
      w_rr_last_nxt    = r_rr_last;
      w_line_cnt_nxt   = r_line_cnt;
      w_rows_lat_nxt   = r_rows_lat;
      w_first_nxt      = r_first;
      w_sof_err_nxt    = r_sof_err;
      w_frame_done_nxt = 1'b0;
      w_flush0         = 1'b0;
      w_flush1         = 1'b0;
      w_done           = 1'b0;
      w_sel_valid      = 1'b0;
      w_sel_last       = 1'b0;
      w_sel_user       = 1'b0;
      w_hs             = 1'b0;
      m_axis_tdata     = '0;
      m_axis_tlast     = 1'b0;
      m_axis_tuser     = 1'b0;
      m_axis_tvalid    = 1'b0;
      s0_axis_tready   = 1'b0;
      s1_axis_tready   = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            // Drop non-SOF head beats so each source resyncs to a frame start.
            w_flush0       = s0_axis_tvalid & ~s0_axis_tuser;
            w_flush1       = s1_axis_tvalid & ~s1_axis_tuser;
            s0_axis_tready = w_flush0;
            s1_axis_tready = w_flush1;
            if (w_req0 | w_req1) begin
               w_grant_nxt    = (w_req1 & (~w_req0 | ~r_rr_last)) ? 2'b10 : 2'b01;
               w_state_nxt    = ST_PASS;
               w_rows_lat_nxt = (vdma_row == '0) ? ROW_W'(1) : vdma_row;
               w_line_cnt_nxt = '0;
               w_first_nxt    = 1'b1;
            end
         end
         ST_PASS: begin
            if (r_grant[1]) begin
               m_axis_tdata   = s1_axis_tdata;
               w_sel_last     = s1_axis_tlast;
               w_sel_user     = s1_axis_tuser;
               w_sel_valid    = s1_axis_tvalid;
               s1_axis_tready = m_axis_tready;
            end else begin
               m_axis_tdata   = s0_axis_tdata;
               w_sel_last     = s0_axis_tlast;
               w_sel_user     = s0_axis_tuser;
               w_sel_valid    = s0_axis_tvalid;
               s0_axis_tready = m_axis_tready;
            end
            m_axis_tlast  = w_sel_last;
            m_axis_tuser  = w_sel_user;
            m_axis_tvalid = w_sel_valid;
            w_hs          = w_sel_valid & m_axis_tready;
            if (w_hs) begin
               w_first_nxt = 1'b0;
               if (w_sel_user & ~r_first) begin
                  w_sof_err_nxt = 1'b1;
               end
               if (w_sel_last) begin
                  if (r_line_cnt == r_rows_lat - ROW_W'(1)) begin
                     w_done           = 1'b1;
                     w_frame_done_nxt = 1'b1;
                     w_rr_last_nxt    = r_grant[1];
                     w_line_cnt_nxt   = '0;
                     w_grant_nxt      = 2'b00;
                     w_state_nxt      = ST_IDLE;
                  end else begin
                     w_line_cnt_nxt = r_line_cnt + ROW_W'(1);
                  end
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      // Nothing moves while reset is asserted.
      if (!s_axis_aresetn) begin
         s0_axis_tready = 1'b0;
         s1_axis_tready = 1'b0;
         m_axis_tvalid  = 1'b0;
      end
   end

   // State and control registers.
   always_ff @(posedge s_axis_aclk) begin
      if (!s_axis_aresetn) begin
         r_state      <= ST_IDLE;
         r_grant      <= 2'b00;
         r_rr_last    <= 1'b1;
         r_line_cnt   <= '0;
         r_rows_lat   <= ROW_W'(1);
         r_first      <= 1'b0;
         r_sof_err    <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_grant      <= w_grant_nxt;
         r_rr_last    <= w_rr_last_nxt;
         r_line_cnt   <= w_line_cnt_nxt;
         r_rows_lat   <= w_rows_lat_nxt;
         r_first      <= w_first_nxt;
         r_sof_err    <= w_sof_err_nxt;
         r_frame_done <= w_frame_done_nxt;
      end
   end

   assign grant      = r_grant;
   assign frame_done = r_frame_done;
   assign sof_err    = r_sof_err;

`ifdef ARB_STATS_EN
   logic [ROW_W-1:0] r_frame_cnt0, r_frame_cnt1, r_drop_cnt;
   logic [ROW_W:0]   w_drop_sum;
   logic [ROW_W-1:0] w_drop_nxt;

   // Saturating sum of beats flushed this cycle (up to one per source).
   always_comb begin
      w_drop_sum = {1'b0, r_drop_cnt} + (ROW_W+1)'(w_flush0) + (ROW_W+1)'(w_flush1);
      w_drop_nxt = w_drop_sum[ROW_W] ? '1 : w_drop_sum[ROW_W-1:0];
   end

   // Per-source completed-frame counters (wrapping) and flush counter.
   always_ff @(posedge s_axis_aclk) begin
      if (!s_axis_aresetn) begin
         r_frame_cnt0 <= '0;
         r_frame_cnt1 <= '0;
         r_drop_cnt   <= '0;
      end else begin
         if (w_done & ~r_grant[1]) r_frame_cnt0 <= r_frame_cnt0 + ROW_W'(1);
         if (w_done &  r_grant[1]) r_frame_cnt1 <= r_frame_cnt1 + ROW_W'(1);
         r_drop_cnt <= w_drop_nxt;
      end
   end

   assign frame_cnt0 = r_frame_cnt0;
   assign frame_cnt1 = r_frame_cnt1;
   assign drop_cnt   = r_drop_cnt;
`endif

endmodule

// File: tb/tb_vdma_frame_arbiter.sv
// Testbench for vdma_frame_arbiter: queue-driven sources, a frame-level reference
// model checked every cycle, and literal expectations for the directed scenarios.
module tb_vdma_frame_arbiter;
   localparam int unsigned TW = 64;
   localparam int unsigned RW = 32;

   logic          clk = 1'b0;
   logic          aresetn = 1'b0;
   logic [RW-1:0] vdma_row = '0;
   logic [TW-1:0] s0_tdata = '0, s1_tdata = '0;
   logic          s0_tlast = 1'b0, s0_tuser = 1'b0, s0_tvalid = 1'b0, s0_tready;
   logic          s1_tlast = 1'b0, s1_tuser = 1'b0, s1_tvalid = 1'b0, s1_tready;
   logic [TW-1:0] m_tdata;
   logic          m_tlast, m_tuser, m_tvalid;
   logic          m_tready = 1'b0;
   logic [1:0]    grant;
   logic          frame_done, sof_err;
`ifdef ARB_STATS_EN
   logic [RW-1:0] frame_cnt0, frame_cnt1, drop_cnt;
`endif

   always #5 clk = ~clk;

   vdma_frame_arbiter #(.TDATA_WIDTH(TW), .ROW_W(RW)) dut (
      .s_axis_aclk(clk), .s_axis_aresetn(aresetn), .vdma_row(vdma_row),
      .s0_axis_tdata(s0_tdata), .s0_axis_tlast(s0_tlast), .s0_axis_tuser(s0_tuser),
      .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready),
      .s1_axis_tdata(s1_tdata), .s1_axis_tlast(s1_tlast), .s1_axis_tuser(s1_tuser),
      .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready),
      .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
`ifdef ARB_STATS_EN
      .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1), .drop_cnt(drop_cnt),
`endif
      .grant(grant), .frame_done(frame_done), .sof_err(sof_err)
   );

   typedef struct packed {
      logic [TW-1:0] d;
      logic          l;
      logic          u;
   } beat_t;

   beat_t q0[$], q1[$];
   int    n_chk = 0, n_fail = 0;

   // stimulus controls, applied just after each rising edge
   logic          nx_rstn = 1'b0;
   logic [RW-1:0] nx_row  = '0;
   bit            flush_q = 0, rdy_rand = 0, gap_en = 0;
   bit            shown0 = 0, shown1 = 0, hs0 = 0, hs1 = 0, armed = 0;

   // reference model state
   int            mo = -1;          // current owner, -1 = none
   int            m_rr = 1;         // owner of last completed frame
   longint        m_left = 0;       // lines still to pass in current frame
   bit            m_first = 0, m_sof = 0, m_fd = 0;
   logic [RW-1:0] m_fc[2];
   logic [RW-1:0] m_drop = '0;

   // observation counters for literal checks
   int            n_mbeats = 0, n_mlast = 0, n_fd = 0, s0_lines = 0, s0_beats = 0;
   logic [1:0]    last_g = 2'b00;
   int            order[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 60) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: drive sources after the rising edge, check and advance the model at the falling edge.
   task automatic tick();
      logic          sv[2], su[2], sl[2];
      logic [TW-1:0] sd[2];
      logic          e_mv, e_r0, e_r1;
      logic [1:0]    e_g;
      int            w;
      @(posedge clk); #1;
      aresetn  = nx_rstn;
      vdma_row = nx_row;
      if (hs0 && q0.size() > 0) void'(q0.pop_front());
      if (hs1 && q1.size() > 0) void'(q1.pop_front());
      if (flush_q) begin q0.delete(); q1.delete(); flush_q = 0; end
      if (q0.size() == 0) shown0 = 0;
      else if (!shown0 || hs0) shown0 = !gap_en || ($urandom_range(3) != 0);
      if (q1.size() == 0) shown1 = 0;
      else if (!shown1 || hs1) shown1 = !gap_en || ($urandom_range(3) != 0);
      s0_tvalid = shown0;
      s1_tvalid = shown1;
      {s0_tdata, s0_tlast, s0_tuser} = (q0.size() > 0) ? q0[0] : '0;
      {s1_tdata, s1_tlast, s1_tuser} = (q1.size() > 0) ? q1[0] : '0;
      m_tready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;

      @(negedge clk);
      sv[0] = s0_tvalid; su[0] = s0_tuser; sl[0] = s0_tlast; sd[0] = s0_tdata;
      sv[1] = s1_tvalid; su[1] = s1_tuser; sl[1] = s1_tlast; sd[1] = s1_tdata;
      e_r0 = 1'b0; e_r1 = 1'b0; e_mv = 1'b0;
      if (!aresetn) begin
         e_mv = 1'b0;
      end else if (mo < 0) begin
         e_r0 = sv[0] & ~su[0];
         e_r1 = sv[1] & ~su[1];
      end else begin
         e_mv = sv[mo];
         if (mo == 0) e_r0 = m_tready; else e_r1 = m_tready;
      end
      e_g = (mo == 0) ? 2'b01 : (mo == 1) ? 2'b10 : 2'b00;
      if (armed) begin
         chk("m_tvalid", 64'(m_tvalid), 64'(e_mv));
         chk("s0_tready", 64'(s0_tready), 64'(e_r0));
         chk("s1_tready", 64'(s1_tready), 64'(e_r1));
         chk("grant", 64'(grant), 64'(e_g));
         chk("frame_done", 64'(frame_done), 64'(m_fd));
         chk("sof_err", 64'(sof_err), 64'(m_sof));
         if (e_mv && mo >= 0) begin
            chk("m_tdata", 64'(m_tdata), 64'(sd[mo]));
            chk("m_tlast", 64'(m_tlast), 64'(sl[mo]));
            chk("m_tuser", 64'(m_tuser), 64'(su[mo]));
         end
`ifdef ARB_STATS_EN
         chk("frame_cnt0", 64'(frame_cnt0), 64'(m_fc[0]));
         chk("frame_cnt1", 64'(frame_cnt1), 64'(m_fc[1]));
         chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
`endif
      end

      // observations
      hs0 = s0_tvalid & s0_tready;
      hs1 = s1_tvalid & s1_tready;
      if (hs0) begin
         if (s0_tlast) begin s0_lines++; s0_beats = 0; end else s0_beats++;
      end
      if (m_tvalid && m_tready) begin
         n_mbeats++;
         if (m_tlast) begin n_mlast++; last_g = grant; end
      end
      if (frame_done) begin n_fd++; order.push_back(last_g == 2'b10 ? 1 : 0); end

      // model advance for the coming edge
      if (!aresetn) begin
         mo = -1; m_rr = 1; m_left = 0; m_first = 0; m_sof = 0; m_fd = 0;
         m_fc[0] = '0; m_fc[1] = '0; m_drop = '0;
         armed = 1;
      end else begin
         m_fd = 0;
         if (mo < 0) begin
            for (int n = 0; n < 2; n++)
               if (sv[n] && !su[n] && m_drop != '1) m_drop = m_drop + 1;
            if ((sv[0] && su[0]) || (sv[1] && su[1])) begin
               if (sv[0] && su[0] && sv[1] && su[1]) w = 1 - m_rr;
               else w = (sv[1] && su[1]) ? 1 : 0;
               mo = w;
               m_left = (vdma_row == 0) ? 1 : longint'(vdma_row);
               m_first = 1;
            end
         end else if (sv[mo] && m_tready) begin
            if (su[mo] && !m_first) m_sof = 1;
            m_first = 0;
            if (sl[mo]) begin
               m_left--;
               if (m_left == 0) begin
                  m_fd = 1; m_rr = mo; m_fc[mo] = m_fc[mo] + 1; mo = -1;
               end
            end
         end
      end
   endtask

   task automatic push_frame(input int src, input int rows, input int bpl,
                             input int xl = -1, input int xb = -1);
      beat_t b;
      for (int l = 0; l < rows; l++)
         for (int k = 0; k < bpl; k++) begin
            b.d = {32'($urandom), 32'($urandom)};
            b.l = (k == bpl - 1);
            b.u = (l == 0 && k == 0) || (l == xl && k == xb);
            if (src == 0) q0.push_back(b); else q1.push_back(b);
         end
   endtask

   task automatic push_junk(input int src, input int n);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b.d = {32'($urandom), 32'($urandom)};
         b.l = 1'($urandom_range(1));
         b.u = 1'b0;
         if (src == 0) q0.push_back(b); else q1.push_back(b);
      end
   endtask

   task automatic clear_obs();
      n_mbeats = 0; n_mlast = 0; n_fd = 0; s0_lines = 0; s0_beats = 0;
      order.delete();
   endtask

   task automatic do_reset();
      nx_rstn = 1'b0;
      flush_q = 1;
      repeat (2) tick();
      nx_rstn = 1'b1;
      clear_obs();
   endtask

   task automatic run_quiet(input string name, input int budget);
      int c = 0;
      while (!(q0.size() == 0 && q1.size() == 0 && mo < 0) && c < budget) begin
         tick(); c++;
      end
      chk({name, "_timeout"}, 64'(c < budget), 64'(1));
      repeat (3) tick();
   endtask

   initial begin
      m_fc[0] = '0; m_fc[1] = '0;
      nx_row = 32'd4;
      do_reset();
      tick();
      chk("rst_grant", 64'(grant), 64'(0));
      chk("rst_frame_done", 64'(frame_done), 64'(0));
      chk("rst_sof_err", 64'(sof_err), 64'(0));
      chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));

      // 1: single source, 4 lines x 8 beats
      push_frame(0, 4, 8);
      tick(); tick();
      chk("t1_grant", 64'(grant), 64'(2'b01));
      run_quiet("t1", 200);
      chk("t1_beats", 64'(n_mbeats), 64'(32));
      chk("t1_tlast", 64'(n_mlast), 64'(4));
      chk("t1_fd", 64'(n_fd), 64'(1));
      chk("t1_grant_after", 64'(grant), 64'(0));

      // 2: both sources start together, 3 frames each
      nx_row = 32'd2;
      do_reset();
      for (int f = 0; f < 3; f++) begin push_frame(0, 2, 3); push_frame(1, 2, 3); end
      run_quiet("t2", 400);
      chk("t2_order_n", 64'(order.size()), 64'(6));
      for (int i = 0; i < order.size() && i < 6; i++)
         chk($sformatf("t2_order%0d", i), 64'(order[i]), 64'(i % 2));
`ifdef ARB_STATS_EN
      chk("t2_fc0", 64'(frame_cnt0), 64'(3));
      chk("t2_fc1", 64'(frame_cnt1), 64'(3));
`endif

      // 3: random backpressure and gaps, vdma_row changed mid-frame
      nx_row = 32'd4;
      do_reset();
      rdy_rand = 1; gap_en = 1;
      push_frame(0, 4, 8);
      repeat (6) tick();
      nx_row = 32'd2;
      run_quiet("t3", 600);
      chk("t3_beats", 64'(n_mbeats), 64'(32));
      chk("t3_tlast", 64'(n_mlast), 64'(4));
      chk("t3_fd", 64'(n_fd), 64'(1));
      chk("t3_sof_err", 64'(sof_err), 64'(0));
      rdy_rand = 0; gap_en = 0;

      // 4: s1 requests while s0 is mid-frame
      nx_row = 32'd4;
      do_reset();
      push_frame(0, 4, 4);
      begin
         int c = 0;
         while (s0_lines < 2 && c < 200) begin tick(); c++; end
         chk("t4_wait_timeout", 64'(c < 200), 64'(1));
      end
      push_frame(1, 4, 2);
      run_quiet("t4", 400);
      chk("t4_fd", 64'(n_fd), 64'(2));
      chk("t4_order_n", 64'(order.size()), 64'(2));
      if (order.size() == 2) begin
         chk("t4_first", 64'(order[0]), 64'(0));
         chk("t4_second", 64'(order[1]), 64'(1));
      end
      chk("t4_beats", 64'(n_mbeats), 64'(24));

      // 5: non-SOF junk flushed, then a frame with a stray tuser
      do_reset();
      push_junk(0, 5);
      push_frame(0, 4, 4, 0, 3);
      run_quiet("t5", 300);
      chk("t5_beats", 64'(n_mbeats), 64'(16));
      chk("t5_sof_err", 64'(sof_err), 64'(1));
`ifdef ARB_STATS_EN
      chk("t5_drop", 64'(drop_cnt), 64'(5));
`endif
      push_frame(0, 4, 2);
      run_quiet("t5b", 200);
      chk("t5_sof_sticky", 64'(sof_err), 64'(1));

      // 6: reset mid-frame, then a vdma_row=0 frame
      do_reset();
      push_frame(0, 4, 8);
      begin
         int c = 0;
         while (!(s0_lines == 2 && s0_beats == 5) && c < 200) begin tick(); c++; end
         chk("t6_wait_timeout", 64'(c < 200), 64'(1));
      end
      nx_rstn = 1'b0; flush_q = 1;
      tick();
      chk("t6_rst_tready0", 64'(s0_tready), 64'(0));
      chk("t6_rst_mvalid", 64'(m_tvalid), 64'(0));
      tick();
      chk("t6_grant", 64'(grant), 64'(0));
      chk("t6_mvalid", 64'(m_tvalid), 64'(0));
      chk("t6_tready1", 64'(s1_tready), 64'(0));
`ifdef ARB_STATS_EN
      chk("t6_fc0", 64'(frame_cnt0), 64'(0));
`endif
      nx_rstn = 1'b1; nx_row = '0;
      clear_obs();
      push_frame(0, 1, 3);
      run_quiet("t6", 100);
      chk("t6_fd", 64'(n_fd), 64'(1));
      chk("t6_beats", 64'(n_mbeats), 64'(3));

      // 7: randomized traffic from both sources
      do_reset();
      rdy_rand = 1; gap_en = 1;
      for (int r = 0; r < 8; r++) begin
         int rows = $urandom_range(3, 1);
         nx_row = RW'(rows);
         for (int n = 0; n < 2; n++) begin
            if ($urandom_range(3) == 0) push_junk(n, $urandom_range(3, 1));
            for (int f = $urandom_range(2); f > 0; f--)
               push_frame(n, rows, $urandom_range(4, 1));
         end
         run_quiet($sformatf("t7_r%0d", r), 1500);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
